// File: rtl/fir_inverse_filter_if.sv
// Handshake bundle between a FIR output stream and the inverse filter.
// FIR_INV_SAT_EN adds the registered sat flag alongside x_out.
interface fir_inverse_filter_if #(
    parameter int WIDTH = 16,
    parameter int N     = 8
) ();
    localparam int YW = 2*WIDTH + $clog2(N) + 1;

    logic signed [YW-1:0]     y_in;
    logic                     in_valid;
    logic                     in_ready;
    logic [N-1:0][WIDTH-1:0]  h;
    logic signed [WIDTH-1:0]  x_out;
    logic                     out_valid;
    logic                     out_ready;
`ifdef FIR_INV_SAT_EN
    logic                     sat;

    modport master (output y_in, in_valid, h, out_ready,
                    input  in_ready, x_out, out_valid, sat);
    modport slave  (input  y_in, in_valid, h, out_ready,
                    output in_ready, x_out, out_valid, sat);
`else
    modport master (output y_in, in_valid, h, out_ready,
                    input  in_ready, x_out, out_valid);
    modport slave  (input  y_in, in_valid, h, out_ready,
                    output in_ready, x_out, out_valid);
`endif
endinterface

// File: rtl/fir_inverse_filter.sv
// All-pole inverse of a monic FIR: x[n] = y[n] - sum h[k]*x[n-k], one tap per cycle.
// FIR_INV_SAT_EN: clamp x_out to WIDTH bits and flag it on sat; otherwise x_out wraps.
module fir_inverse_filter #(
    parameter int WIDTH = 16,
    parameter int N     = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    fir_inverse_filter_if.slave   bus
);
    localparam int YW   = 2*WIDTH + $clog2(N) + 1;
    localparam int ACCW = YW + 1;
    localparam int KW   = (N > 1) ? $clog2(N) : 1;
    localparam int HN   = (N > 1) ? N - 1 : 1;

    localparam logic signed [ACCW-1:0] MAXV = {{(ACCW-WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
    localparam logic signed [ACCW-1:0] MINV = {{(ACCW-WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, MAC, DONE} state_t;

    state_t                   state;
    logic signed [ACCW-1:0]   acc;
    logic signed [ACCW-1:0]   acc_sub;
    logic signed [ACCW-1:0]   y_ext;
    logic [KW-1:0]            k;
    logic [KW-1:0]            hidx;
    logic signed [WIDTH-1:0]  hist [HN];
    logic signed [WIDTH-1:0]  h_k;
    logic signed [WIDTH-1:0]  hist_k;
    logic signed [2*WIDTH-1:0] prod;
    logic [WIDTH:0]           x_load;
    logic                     x_sat;
    logic signed [WIDTH-1:0]  x_val;

    function automatic logic [WIDTH:0] to_x(input logic signed [ACCW-1:0] a);
`ifdef FIR_INV_SAT_EN
        if (a > MAXV)
            return {1'b1, MAXV[WIDTH-1:0]};
        else if (a < MINV)
            return {1'b1, MINV[WIDTH-1:0]};
        else
            return {1'b0, a[WIDTH-1:0]};
`else
        return {1'b0, a[WIDTH-1:0]};
`endif
    endfunction

    assign y_ext   = {bus.y_in[YW-1], bus.y_in};
    assign hidx    = (N > 1) ? k - 1'b1 : '0;
    assign h_k     = $signed(bus.h[k]);
    assign hist_k  = hist[hidx];
    assign prod    = h_k * hist_k;
    assign acc_sub = acc - {{(ACCW-2*WIDTH){prod[2*WIDTH-1]}}, prod};
    // With a single tap the result comes straight from the loaded sample.
    assign x_load  = to_x((N == 1) ? y_ext : acc_sub);
    assign {x_sat, x_val} = x_load;

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            acc           <= '0;
            k             <= '0;
            bus.in_ready  <= 1'b1;
            bus.out_valid <= 1'b0;
            bus.x_out     <= '0;
`ifdef FIR_INV_SAT_EN
            bus.sat       <= 1'b0;
`endif
            for (int i = 0; i < HN; i++) hist[i] <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid && bus.in_ready) begin
                        acc          <= y_ext;
                        k            <= KW'(1);
                        bus.in_ready <= 1'b0;
                        if (N == 1) begin
                            state         <= DONE;
                            bus.out_valid <= 1'b1;
                            bus.x_out     <= x_val;
`ifdef FIR_INV_SAT_EN
                            bus.sat       <= x_sat;
`endif
                        end else begin
                            state <= MAC;
                        end
                    end
                end
                MAC: begin
                    acc <= acc_sub;
                    k   <= k + 1'b1;
                    if (k == KW'(N-1)) begin
                        state         <= DONE;
                        bus.out_valid <= 1'b1;
                        bus.x_out     <= x_val;
`ifdef FIR_INV_SAT_EN
                        bus.sat       <= x_sat;
`endif
                    end
                end
                DONE: begin
                    // History holds what was presented, so wrapped/clamped values feed back.
                    if (bus.out_ready) begin
                        hist[0] <= bus.x_out;
                        for (int i = 1; i < HN; i++) hist[i] <= hist[i-1];
                        bus.out_valid <= 1'b0;
                        bus.in_ready  <= 1'b1;
                        k             <= '0;
                        state         <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_fir_inverse_filter.sv
// Directed bench: ramp recovery, latency, backpressure, mid-sample reset, overflow.
module tb_fir_inverse_filter;
    localparam int WIDTH = 16;
    localparam int N     = 8;
    localparam int YW    = 2*WIDTH + $clog2(N) + 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    fir_inverse_filter_if #(.WIDTH(WIDTH), .N(N)) bus ();

    fir_inverse_filter #(.WIDTH(WIDTH), .N(N)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic check(input string tag, input longint got, input longint exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Forward monic FIR of x[m] = m+1 with taps 1..8, used to build the ramp stimulus.
    function automatic longint ramp_y(input int n);
        longint s = 0;
        for (int j = 0; j < N; j++)
            if (n - j >= 0) s += longint'(j + 1) * longint'(n - j + 1);
        return s;
    endfunction

    task automatic set_taps(input int h0);
        bus.h[0] = WIDTH'(h0);
        for (int i = 1; i < N; i++) bus.h[i] = WIDTH'(i + 1);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic wait_in_ready();
        int n = 0;
        while (!bus.in_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!bus.in_ready) check("in_ready_timeout", 0, 1);
    endtask

    task automatic run_sample(input longint y, input longint exp, input int hold);
        int edges;
        wait_in_ready();
        bus.y_in      = YW'(y);
        bus.in_valid  = 1'b1;
        bus.out_ready = (hold == 0);
        @(negedge clk);
        bus.in_valid = 1'b0;
        edges = 1;
        while (!bus.out_valid && edges < 40) begin
            check("busy_in_ready", bus.in_ready, 0);
            @(negedge clk);
            edges++;
        end
        check("latency", edges, N);
        check("done_in_ready", bus.in_ready, 0);
        for (int i = 0; i < hold; i++) begin
            check("bp_x", bus.x_out, exp);
            check("bp_valid", bus.out_valid, 1);
            check("bp_in_ready", bus.in_ready, 0);
            @(negedge clk);
        end
        bus.out_ready = 1'b1;
        check("x_out", bus.x_out, exp);
        @(negedge clk);
        check("valid_pulse", bus.out_valid, 0);
        check("in_ready_back", bus.in_ready, 1);
    endtask

    initial begin
        bus.y_in      = '0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        set_taps(1);
        do_reset();
        check("rst_in_ready", bus.in_ready, 1);
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_x_out", bus.x_out, 0);
`ifdef FIR_INV_SAT_EN
        check("rst_sat", bus.sat, 0);
`endif

        // Ramp, with 5 cycles of backpressure on sample 9.
        for (int n = 0; n < 16; n++)
            run_sample(ramp_y(n), n + 1, (n == 8) ? 5 : 0);

        // h[0] must not matter.
        do_reset();
        set_taps(7);
        for (int n = 0; n < 16; n++)
            run_sample(ramp_y(n), n + 1, 0);

        // Abort sample 5 in MAC, then restart from a clean history.
        do_reset();
        set_taps(1);
        for (int n = 0; n < 4; n++)
            run_sample(ramp_y(n), n + 1, 0);
        wait_in_ready();
        bus.y_in     = YW'(ramp_y(4));
        bus.in_valid = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_out_valid", bus.out_valid, 0);
        check("abort_in_ready", bus.in_ready, 1);
        check("abort_x_out", bus.x_out, 0);
        run_sample(5, 5, 0);

        // Overflow with a pass-through tap set.
        do_reset();
        for (int i = 0; i < N; i++) bus.h[i] = '0;
        bus.h[0] = WIDTH'(1);
`ifdef FIR_INV_SAT_EN
        run_sample(40000, 32767, 0);
        check("sat_hi", bus.sat, 1);
        run_sample(-40000, -32768, 0);
        check("sat_lo", bus.sat, 1);
        run_sample(-5, -5, 0);
        check("sat_clear", bus.sat, 0);
`else
        run_sample(40000, -25536, 0);
        run_sample(-40000, 25536, 0);
        run_sample(-5, -5, 0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
